// File: rtl/up_down_pkg.sv
// rtl/up_down_pkg.sv - shared types and helpers for the up/down command stage
//
// Purpose: default widths, the command and repeat-state enums, and the
// fixed-priority arbiter shared by the command generator.
package up_down_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_DOWN = 2'd2,
    CMD_UP   = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Same-cycle press events resolve load > down > up, matching the counter.
  // Losers are dropped rather than queued.
  function automatic cmd_t arbitrate(input logic load_ev,
                                     input logic down_ev,
                                     input logic up_ev);
    cmd_t c;
    c = CMD_NONE;
    if (load_ev)      c = CMD_LOAD;
    else if (down_ev) c = CMD_DOWN;
    else if (up_ev)   c = CMD_UP;
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer and press detector
//
// Purpose: brings one raw asynchronous button into the clk domain through two
// flops, accepts a level change only after DEBOUNCE_CYCLES consecutive
// samples disagree with the current stable level, and flags the cycle in
// which the stable level rises.
//
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   btn    in  raw asynchronous button, active high
//   level  out debounced button level
//   press  out combinational, high for the one cycle after the stable level
//              rises (release produces nothing)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  // A one-cycle debounce still needs a 1-bit counter to stay well formed.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          stable_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample agreeing with the stable level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/up_down_cmd_gen.sv
// rtl/up_down_cmd_gen.sv - button conditioning and command pulse generator for the up/down counter
//
// Purpose: conditions the up, down and load buttons, arbitrates their press
// events into registered single-cycle up/down/load pulses and captures the
// synchronised load switches into in_val alongside each load pulse.
// Optional feature macro: UP_DOWN_CMD_REPEAT_EN adds auto-repeat for a held
// up or down button (first repeat after REPEAT_DELAY cycles, then one every
// REPEAT_PERIOD cycles), gated by the counter's high/low flags.
//
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   btn_up    in  raw asynchronous up button
//   btn_down  in  raw asynchronous down button
//   btn_load  in  raw asynchronous load button
//   sw_in     in  raw asynchronous load switches [WIDTH-1:0]
//   low       in  counter-at-zero flag (gates down repeats)
//   high      in  counter-at-max flag (gates up repeats)
//   up        out one-cycle up command
//   down      out one-cycle down command
//   load      out one-cycle load command
//   in_val    out load value [WIDTH-1:0], updated with each load pulse
module up_down_cmd_gen
  import up_down_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             low,
  input  logic             high,
  output logic             up,
  output logic             down,
  output logic             load,
  output logic [WIDTH-1:0] in_val
);

  logic             up_level;
  logic             down_level;
  logic             load_level;
  logic             up_press;
  logic             down_press;
  logic             load_press;
  logic [WIDTH-1:0] sw_s1_q;
  logic [WIDTH-1:0] sw_s2_q;
  logic             up_q;
  logic             down_q;
  logic             load_q;
  logic [WIDTH-1:0] in_val_q;
  cmd_t             press_cmd;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .level (up_level),
    .press (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .level (down_level),
    .press (down_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .level (load_level),
    .press (load_press)
  );

  // The switches are only sampled on a load pulse, long after a human has
  // settled them, so a plain two-flop synchroniser without debounce suffices.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign press_cmd = arbitrate(load_press, down_press, up_press);

`ifdef UP_DOWN_CMD_REPEAT_EN

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  rpt_state_t     rpt_state_q;
  logic           rpt_dir_up_q;
  logic [RCW-1:0] rcnt_q;
  logic           rpt_held;
  logic           rpt_allow;
  logic           unused_load_level;

  // The repeating direction must still be held; the counter flag at the end
  // it is heading toward silences the pulse but leaves the timing running.
  assign rpt_held          = rpt_dir_up_q ? up_level : down_level;
  assign rpt_allow         = rpt_dir_up_q ? ~high : ~low;
  assign unused_load_level = load_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      load_q       <= 1'b0;
      in_val_q     <= '0;
      rpt_state_q  <= RPT_IDLE;
      rpt_dir_up_q <= 1'b0;
      rcnt_q       <= '0;
    end else begin
      up_q   <= (press_cmd == CMD_UP);
      down_q <= (press_cmd == CMD_DOWN);
      load_q <= (press_cmd == CMD_LOAD);
      if (press_cmd == CMD_LOAD) begin
        in_val_q <= sw_s2_q;
      end

      // A fresh press always wins over the repeat machine: load stops any
      // repeat, an up/down press (re)starts the delay in its own direction.
      if ((press_cmd == CMD_UP) || (press_cmd == CMD_DOWN)) begin
        rpt_state_q  <= RPT_DELAY;
        rpt_dir_up_q <= (press_cmd == CMD_UP);
        rcnt_q       <= '0;
      end else if (press_cmd == CMD_LOAD) begin
        rpt_state_q <= RPT_IDLE;
        rcnt_q      <= '0;
      end else begin
        case (rpt_state_q)
          RPT_IDLE: begin
            rcnt_q <= '0;
          end
          RPT_DELAY: begin
            if (!rpt_held) begin
              rpt_state_q <= RPT_IDLE;
              rcnt_q      <= '0;
            end else if (rcnt_q == DELAY_LAST) begin
              up_q        <= rpt_allow & rpt_dir_up_q;
              down_q      <= rpt_allow & ~rpt_dir_up_q;
              rpt_state_q <= RPT_REPEAT;
              rcnt_q      <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (!rpt_held) begin
              rpt_state_q <= RPT_IDLE;
              rcnt_q      <= '0;
            end else if (rcnt_q == PERIOD_LAST) begin
              up_q   <= rpt_allow & rpt_dir_up_q;
              down_q <= rpt_allow & ~rpt_dir_up_q;
              rcnt_q <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: begin
            rpt_state_q <= RPT_IDLE;
            rcnt_q      <= '0;
          end
        endcase
      end
    end
  end

`else

  // Without repeat the counter flags and repeat timing have no effect; the
  // counter saturates on its own.
  logic unused_rpt;
  assign unused_rpt = low ^ high ^ up_level ^ down_level ^ load_level ^
                      (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      load_q   <= 1'b0;
      in_val_q <= '0;
    end else begin
      up_q   <= (press_cmd == CMD_UP);
      down_q <= (press_cmd == CMD_DOWN);
      load_q <= (press_cmd == CMD_LOAD);
      if (press_cmd == CMD_LOAD) begin
        in_val_q <= sw_s2_q;
      end
    end
  end

`endif

  assign up     = up_q;
  assign down   = down_q;
  assign load   = load_q;
  assign in_val = in_val_q;

endmodule

// File: tb/tb_up_down_cmd_gen.sv
// tb/tb_up_down_cmd_gen.sv - scoreboard testbench for up_down_cmd_gen
module tb_up_down_cmd_gen;
  import up_down_pkg::*;

  localparam int W  = 5;
  localparam int DC = 4;
  localparam int RD = 16;
  localparam int RP = 4;
  localparam logic [15:0] WMASK = 16'((1 << DC) - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_load = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic         low = 1'b0;
  logic         high = 1'b0;
  logic         up;
  logic         down;
  logic         load;
  logic [W-1:0] in_val;

  up_down_cmd_gen #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_load(btn_load), .sw_in(sw_in), .low(low), .high(high),
    .up(up), .down(down), .load(load), .in_val(in_val)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int unsigned  edge_no;
    cmd_t         cmd;
    logic [W-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void check(input string name, input logic ok,
                                input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s at edge %0d: got %0d, required %0d", name, edge_n, act, req);
  endfunction

  // ---------------- reference model ----------------
  // Buttons indexed 0=up, 1=down, 2=load. Raw inputs reach the debouncer two
  // edges late; the debounced level flips once the DC most recent samples
  // taken since the last flip all disagree with it.
  logic         m_sync0[3];
  logic         m_sync1[3];
  logic         m_st[3];
  logic         m_st_prev[3];
  logic [15:0]  m_hist[3];
  int           m_since[3];
  logic [W-1:0] m_sw0, m_sw1;
  int           m_active;
  int unsigned  m_next;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_sync0[b] = 0; m_sync1[b] = 0; m_st[b] = 0; m_st_prev[b] = 0;
      m_hist[b] = '0; m_since[b] = 0;
    end
    m_sw0 = '0; m_sw1 = '0; m_active = 0; m_next = 0;
  endtask

  task automatic push_exp(input int unsigned k, input cmd_t c, input logic [W-1:0] v);
    exp_t e;
    e.edge_no = k; e.cmd = c; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic r, input logic [2:0] raw,
                            input logic [W-1:0] sw, input logic lo, input logic hi);
    int unsigned k;
    logic        press[3];
    logic        s;
    cmd_t        c;
    k = edge_n + 1;
    if (r) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 3; b++) press[b] = m_st[b] && !m_st_prev[b];
    if (press[2])      c = CMD_LOAD;
    else if (press[1]) c = CMD_DOWN;
    else if (press[0]) c = CMD_UP;
    else               c = CMD_NONE;
    if (c != CMD_NONE) push_exp(k, c, m_sw1);
`ifdef UP_DOWN_CMD_REPEAT_EN
    if (c == CMD_LOAD) m_active = 0;
    else if (c == CMD_UP) begin m_active = 1; m_next = k + RD; end
    else if (c == CMD_DOWN) begin m_active = 2; m_next = k + RD; end
    else if (m_active != 0) begin
      if (!m_st[m_active-1]) m_active = 0;
      else if (k == m_next) begin
        if (m_active == 1 && !hi) push_exp(k, CMD_UP, '0);
        if (m_active == 2 && !lo) push_exp(k, CMD_DOWN, '0);
        m_next = k + RP;
      end
    end
`endif
    for (int b = 0; b < 3; b++) begin
      s = m_sync1[b];
      m_st_prev[b] = m_st[b];
      m_hist[b] = {m_hist[b][14:0], s};
      m_since[b]++;
      if (m_since[b] >= DC &&
          (m_st[b] ? ((m_hist[b] & WMASK) == 16'd0) : ((m_hist[b] & WMASK) == WMASK))) begin
        m_st[b] = s;
        m_since[b] = 0;
      end
      m_sync1[b] = m_sync0[b];
      m_sync0[b] = raw[b];
    end
    m_sw1 = m_sw0;
    m_sw0 = sw;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] last_load = '0;
  cmd_t         mon_got;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", {up, down, load, in_val} == '0, {up, down, load, in_val}, 0);
      last_load = '0;
    end else begin
      check("one_hot", (int'(up) + int'(down) + int'(load)) <= 1, {up, down, load}, 0);
      if (up || down || load) begin
        mon_got = load ? CMD_LOAD : (down ? CMD_DOWN : CMD_UP);
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
          check("missed_pulse", 1'b0, 0, int'(exp_q[0].cmd));
          void'(exp_q.pop_front());
        end
        if (exp_q.size() == 0 || exp_q[0].edge_no != edge_n) begin
          check("unexpected_pulse", 1'b0, int'(mon_got), int'(CMD_NONE));
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_cmd", mon_got == mon_e.cmd, int'(mon_got), int'(mon_e.cmd));
          if (mon_e.cmd == CMD_LOAD) begin
            check("load_value", in_val == mon_e.val, in_val, mon_e.val);
            last_load = mon_e.val;
          end
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
          check("missed_pulse", 1'b0, 0, int'(exp_q[0].cmd));
          void'(exp_q.pop_front());
        end
        check("in_val_hold", in_val == last_load, in_val, last_load);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic r, input logic u, input logic d, input logic l,
                       input logic [W-1:0] sw, input logic lo, input logic hi, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      rst = r; btn_up = u; btn_down = d; btn_load = l;
      sw_in = sw; low = lo; high = hi;
      model_step(r, {l, d, u}, sw, lo, hi);
    end
  endtask

  logic [2:0]   lv;
  int           run[3];
  logic [W-1:0] rsw;
  logic         rlo, rhi;

  initial begin
    model_reset();
    // reset with every button held, then keep them held
    apply(1, 1, 1, 1, 5'b01101, 0, 0, 3);
    apply(0, 1, 1, 1, 5'b01101, 0, 0, 20);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 15);
    // short glitch, then a long hold
    apply(0, 1, 0, 0, 5'b00000, 0, 0, 2);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 12);
    apply(0, 1, 0, 0, 5'b00000, 0, 0, 20);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 12);
    // load and up together
    apply(0, 1, 0, 1, 5'b10110, 0, 0, 12);
    apply(0, 0, 0, 0, 5'b10110, 0, 0, 12);
    // held down, then held down with low asserted part way
    apply(0, 0, 1, 0, 5'b00000, 0, 0, 40);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 15);
    apply(0, 0, 1, 0, 5'b00000, 0, 0, 19);
    apply(0, 0, 1, 0, 5'b00000, 1, 0, 21);
    apply(0, 0, 0, 0, 5'b00000, 1, 0, 15);
    apply(0, 1, 0, 0, 5'b00000, 1, 0, 30);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 15);
    // up then down ten cycles later, both held
    apply(0, 1, 0, 0, 5'b00000, 0, 0, 10);
    apply(0, 1, 1, 0, 5'b00000, 0, 0, 50);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 15);
    // held up at the top of the range
    apply(0, 1, 0, 0, 5'b00000, 0, 1, 40);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 15);
    // reset while a button is held
    apply(0, 1, 0, 0, 5'b00000, 0, 0, 8);
    apply(1, 1, 0, 0, 5'b00000, 0, 0, 2);
    apply(0, 1, 0, 0, 5'b00000, 0, 0, 15);
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 15);
    // randomized button activity
    lv = '0; rsw = '0; rlo = 0; rhi = 0;
    for (int b = 0; b < 3; b++) run[b] = $urandom_range(1, 20);
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          lv[b] = ~lv[b];
          run[b] = lv[b] ? $urandom_range(1, 45) : $urandom_range(1, 25);
        end
        run[b]--;
      end
      if ($urandom_range(0, 3) == 0) rsw = W'($urandom);
      if ($urandom_range(0, 9) == 0) rlo = ~rlo;
      if ($urandom_range(0, 9) == 0) rhi = ~rhi;
      apply(($urandom_range(0, 399) == 0), lv[0], lv[1], lv[2], rsw, rlo, rhi, 1);
    end
    apply(0, 0, 0, 0, 5'b00000, 0, 0, 30);
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      check("pending_pulse", 1'b0, 0, int'(exp_q[0].cmd));
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
